div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data.
REQ-002 clk  in  1  Single clock; all state updates on its rising edge.
REQ-003 rst  in  1  Reset, asynchronous and active-low.
REQ-004 start  in  1  Operand-valid strobe from the divisor-alignment stage; sampled only in IDLE.
REQ-005 a  in  32  Dividend magnitude (unsigned).
REQ-006 shiftb  in  32  Divisor magnitude pre-shifted left by cnt (aligned divisor).
REQ-007 cnt  in  5  Alignment shift count (0..31).
REQ-008 neg_q  in  1  Negate the quotient at completion (signed DIV, operand signs differ).
REQ-009 neg_r  in  1  Negate the remainder at completion (signed DIV, dividend negative).
REQ-010 quot  out  32  Quotient (MIPS LO).
REQ-011 rem  out  32  Remainder (MIPS HI).
REQ-012 busy  out  1  High while an operation is in progress.
REQ-013 done  out  1  Single-cycle completion pulse.
REQ-014 div_zero  out  1  High with done when shiftb was zero at start.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN, FIX.
REQ-016 IDLE, start=1, shiftb!=0: SHALL load r_reg=a, d_reg=shiftb, k=cnt, q_reg=0, latch neg_q/neg_r; go to RUN; busy=1 from this edge.
REQ-017 IDLE, start=1, shiftb==0: SHALL go directly to FIX with q_reg=0, r_reg=a, and SHALL force the sign flags to 0 and set div_zero.
REQ-018 RUN, each edge: if r_reg>=d_reg (unsigned, 32-bit) then r_reg-=d_reg and q_reg=(q_reg<<1)|1, else q_reg=q_reg<<1; d_reg>>=1 (logical).
REQ-019 RUN: if k==0 on that edge, go to FIX; otherwise k decrements; RUN therefore lasts exactly cnt+1 edges.
REQ-020 FIX edge: SHALL register quot = neg_q ? two's-complement(q_reg) : q_reg, and rem = neg_r ? two's-complement(r_reg) : r_reg; set done=1, busy=0; return to IDLE.
REQ-021 done SHALL be high for exactly one cycle, cnt+2 edges after the start-sampling edge (1 edge for divide-by-zero).
REQ-022 quot, rem, and div_zero SHALL hold their values until the next FIX edge; div_zero SHALL be cleared when the next operation is accepted.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-024 start in the cycle where done=1 (state IDLE) SHALL be accepted normally.
REQ-025 Inputs other than start SHALL be sampled only on the accepting edge; later changes SHALL have no effect.
REQ-026 All arithmetic SHALL be 32-bit modulo; carry out of the subtraction SHALL be discarded.

Reset
REQ-027 rst low SHALL immediately force state=IDLE, quot=0, rem=0, busy=0, done=0, div_zero=0, and clear internal q_reg/r_reg/d_reg/k.
REQ-028 Reset asserted mid-RUN or in FIX SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted.

Verification
REQ-029 a=100, shiftb=56, cnt=3, neg=0/0 -> done 5 edges after start, quot=14, rem=2, div_zero=0.
REQ-030 a=7, shiftb=4, cnt=1, neg_q=1, neg_r=1 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF, done 3 edges after start.
REQ-031 a=5, shiftb=9, cnt=0 -> quot=0, rem=5, done 2 edges after start.
REQ-032 a=0x12345678, shiftb=0 -> done 1 edge after start, div_zero=1, quot=0, rem=0x12345678.
REQ-033 Second start pulse at edge 2 of the REQ-029 operation -> ignored, same result; rst low at edge 3 -> busy=0, no done, outputs 0.
REQ-034 Back-to-back operation: start asserted in the done cycle of the REQ-029 operation with the REQ-031 operands -> second done 2 edges later, quot=0, rem=5.

Source files
------------

// File: rtl/div_iter.sv
// Iterative restoring divider back end for 32-bit MIPS DIV/DIVU.
// The caller supplies the dividend magnitude, the divisor already aligned
// left by cnt, and the sign-fix flags. One quotient bit is produced per
// RUN edge, and the signs are applied on the final FIX edge.
//
//  state | meaning
//  IDLE  | waiting for start; outputs hold the last result
//  RUN   | one shift/subtract step per edge, cnt+1 edges in total
//  FIX   | apply the sign corrections, register quot/rem, pulse done
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] shiftb,
    input  logic [4:0]  cnt,
    input  logic        neg_q,
    input  logic        neg_r,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic [31:0] d_reg;
    logic [4:0]  k;
    logic        nq;
    logic        nr;

    // Sequencer and datapath: every output is registered, and done defaults low so it lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            q_reg    <= 32'd0;
            r_reg    <= 32'd0;
            d_reg    <= 32'd0;
            k        <= 5'd0;
            nq       <= 1'b0;
            nr       <= 1'b0;
            quot     <= 32'd0;
            rem      <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        r_reg <= a;
                        q_reg <= 32'd0;
                        if (shiftb != 32'd0) begin
                            d_reg    <= shiftb;
                            k        <= cnt;
                            nq       <= neg_q;
                            nr       <= neg_r;
                            div_zero <= 1'b0;
                            state    <= RUN;
                        end else begin
                            // Divide by zero skips the iteration and reports the raw dividend as the remainder.
                            d_reg    <= 32'd0;
                            k        <= 5'd0;
                            nq       <= 1'b0;
                            nr       <= 1'b0;
                            div_zero <= 1'b1;
                            state    <= FIX;
                        end
                    end
                end
                RUN: begin
                    if (r_reg >= d_reg) begin
                        r_reg <= r_reg - d_reg;
                        q_reg <= {q_reg[30:0], 1'b1};
                    end else begin
                        q_reg <= {q_reg[30:0], 1'b0};
                    end
                    d_reg <= d_reg >> 1;
                    if (k == 5'd0) begin
                        state <= FIX;
                    end else begin
                        k <= k - 5'd1;
                    end
                end
                FIX: begin
                    quot  <= nq ? (32'd0 - q_reg) : q_reg;
                    rem   <= nr ? (32'd0 - r_reg) : r_reg;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
